// File: rtl/riscv_mem_arb_pkg.sv
// ============================================================================
// Module      : riscv_mem_arb_pkg
// Description : Shared types and constants for the fetch/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = 4;

    localparam logic [BE_W-1:0] c_BE_FULL = 4'hF;

endpackage

`default_nettype wire

// File: rtl/riscv_mem_arb_fairness.sv
// ============================================================================
// Module      : riscv_mem_arb_fairness
// Description : Starvation counter; forces a fetch grant after STARVE_LIMIT
//               consecutive data grants while a fetch is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem_arb_fairness #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_grant,
    input  logic if_grant,
    input  logic arb_cycle,
    output logic force_if
);

    localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (arb_cycle) begin
            if (if_grant || !if_req) begin
                starve_cnt_d = 4'd0;
            end else if (d_grant && (starve_cnt_q != c_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign force_if = if_req && (starve_cnt_q == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/riscv_mem_arbiter.sv
// ============================================================================
// Module      : riscv_mem_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               data requesters, one transaction at a time, data-priority
//               with fetch starvation protection.
//               Optional stall counters: define RISCV_MEM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem_arbiter
    import riscv_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef RISCV_MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_d_stall
`endif
);

    arb_state_e        state_q,     state_d;
    arb_owner_e        owner_q,     owner_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q,    mem_be_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q,  d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

    logic w_arb;
    logic w_force_if;
    logic w_sel_if;
    logic w_sel_d;

    // Grants are combinational in IDLE; reset masks them so all outputs read 0.
    assign w_arb    = (state_q == IDLE) && !rst;
    assign w_sel_if = w_arb && if_req && (!d_req || w_force_if);
    assign w_sel_d  = w_arb && d_req && !w_sel_if;

    riscv_mem_arb_fairness #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fairness (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .d_grant   (w_sel_d),
        .if_grant  (w_sel_if),
        .arb_cycle (w_arb),
        .force_if  (w_force_if)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (w_sel_if) begin
                    owner_d     = OWN_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = c_BE_FULL;
                    state_d     = ISSUE;
                end else if (w_sel_d) begin
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end else begin
                        d_rdata_d  = mem_we_q ? '0 : mem_rdata;
                        d_rvalid_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt    = w_sel_if;
    assign d_gnt     = w_sel_d;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

`ifdef RISCV_MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall_q, perf_if_stall_d;
    logic [31:0] perf_d_stall_q,  perf_d_stall_d;

    always_comb begin
        perf_if_stall_d = perf_if_stall_q + {31'd0, (if_req && !w_sel_if)};
        perf_d_stall_d  = perf_d_stall_q  + {31'd0, (d_req  && !w_sel_d)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_stall_q <= 32'd0;
            perf_d_stall_q  <= 32'd0;
        end else begin
            perf_if_stall_q <= perf_if_stall_d;
            perf_d_stall_q  <= perf_d_stall_d;
        end
    end

    assign perf_if_stall = perf_if_stall_q;
    assign perf_d_stall  = perf_d_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
// ============================================================================
// Module      : tb_riscv_mem_arbiter
// Description : Self-checking bench for riscv_mem_arbiter with a latency
//               memory model and a protocol-level reference scoreboard.
//               Stall-counter checks are active with RISCV_MEM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_riscv_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef RISCV_MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall, perf_d_stall;
`endif

    riscv_mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef RISCV_MEM_ARB_PERF_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_d_stall  (perf_d_stall)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Values applied to the DUT just after the next rising edge.
    logic        drv_rst = 1'b1, drv_if_req = 1'b0, drv_d_req = 1'b0, drv_d_we = 1'b0;
    logic [31:0] drv_if_addr = '0, drv_d_addr = '0, drv_d_wdata = '0;
    logic [3:0]  drv_d_be = '0;

    // Memory model: answers each mem_req exactly mm_lat cycles later.
    int          mm_lat = 1;
    logic [31:0] mm_next_data = '0;
    bit          mm_pend = 1'b0;
    int          mm_cnt = 0;
    logic [31:0] mm_data = '0;

    task automatic cycle();
        @(posedge clk);
        #1;
        rst     = drv_rst;
        if_req  = drv_if_req;
        if_addr = drv_if_addr;
        d_req   = drv_d_req;
        d_we    = drv_d_we;
        d_addr  = drv_d_addr;
        d_wdata = drv_d_wdata;
        d_be    = drv_d_be;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (mm_pend) begin
            mm_cnt = mm_cnt - 1;
            if (mm_cnt <= 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mm_data;
                mm_pend    = 1'b0;
            end
        end
        @(negedge clk);
        cyc = cyc + 1;
        if (mem_req) begin
            mm_pend = 1'b1;
            mm_cnt  = mm_lat;
            mm_data = mm_next_data;
        end
    endtask

    task automatic wait_rv(input bit want_if, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (want_if ? if_rvalid : d_rvalid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic reset_dut();
        drv_rst = 1'b1; drv_if_req = 1'b0; drv_d_req = 1'b0;
        cycle();
        cycle();
        drv_rst = 1'b0;
        mm_pend = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        drv_rst = 1'b1;
        cycle();
        drv_if_req = 1'b1; drv_d_req = 1'b1;
        cycle();
        tests_run++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b required=000000",
                     {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data addr=%h wdata=%h be=%h if_rdata=%h d_rdata=%h required all 0",
                     mem_addr, mem_wdata, mem_be, if_rdata, d_rdata);
        end
        drv_if_req = 1'b0; drv_d_req = 1'b0;
        cycle();
        drv_rst = 1'b0;
        cycle();
    endtask

    task automatic test_single_fetch();
        bit ok;
        mm_lat = 2; mm_next_data = 32'hDEADBEEF;
        drv_if_req = 1'b1; drv_if_addr = 32'h100;
        cycle();
        tests_run++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_gnt got if=%b d=%b required if=1 d=0", if_gnt, d_gnt);
        end
        drv_if_req = 1'b0; drv_if_addr = 32'h0BAD_0BAD;
        cycle();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'hF || mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_issue got req=%b addr=%h be=%h we=%b required 1 00000100 f 0",
                     mem_req, mem_addr, mem_be, mem_we);
        end
        cycle();
        tests_run++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL fetch_wait got req=%b addr=%h required 0 00000100", mem_req, mem_addr);
        end
        cycle();
        tests_run++;
        if (if_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_early_rv got=%b required=0 at cycle 3", if_rvalid);
        end
        cycle();
        tests_run++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_resp got rv=%b data=%h drv=%b required 1 deadbeef 0",
                     if_rvalid, if_rdata, d_rvalid);
        end
        cycle();
        ok = (if_rvalid === 1'b0);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL fetch_rv_pulse got=%b required=0", if_rvalid);
        end
    endtask

    task automatic test_simultaneous();
        bit seen, early_if;
        mm_lat = 1; mm_next_data = 32'h0BADF00D;
        drv_if_req = 1'b1; drv_if_addr = 32'h180;
        drv_d_req = 1'b1; drv_d_we = 1'b0; drv_d_addr = 32'h200; drv_d_be = 4'hF;
        cycle();
        tests_run++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_first got if=%b d=%b required if=0 d=1", if_gnt, d_gnt);
        end
        drv_d_req = 1'b0;
        seen = 1'b0; early_if = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (if_gnt) early_if = 1'b1;
            if (d_rvalid) begin seen = 1'b1; break; end
        end
        tests_run++;
        if (!seen || early_if || d_rdata !== 32'h0BADF00D) begin
            tests_failed++;
            $display("FAIL simul_dresp got seen=%b early_if=%b data=%h required 1 0 0badf00d",
                     seen, early_if, d_rdata);
        end
        mm_next_data = 32'h600DCAFE;
        cycle();
        tests_run++;
        if (if_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_if_next got if_gnt=%b required=1", if_gnt);
        end
        drv_if_req = 1'b0;
        wait_rv(1'b1, 20, seen);
        tests_run++;
        if (!seen || if_rdata !== 32'h600DCAFE) begin
            tests_failed++;
            $display("FAIL simul_ifresp got seen=%b data=%h required 1 600dcafe", seen, if_rdata);
        end
    endtask

    task automatic test_starvation();
        bit seq[10];
        int got;
        bit both, seen;
        mm_lat = 1;
        drv_if_req = 1'b1; drv_if_addr = 32'h400;
        drv_d_req = 1'b1; drv_d_we = 1'b0; drv_d_addr = 32'h800;
        got = 0; both = 1'b0;
        for (int i = 0; i < 200 && got < 10; i++) begin
            cycle();
            if (if_gnt && d_gnt) both = 1'b1;
            if (if_gnt || d_gnt) begin
                seq[got] = if_gnt;
                got++;
            end
        end
        drv_if_req = 1'b0; drv_d_req = 1'b0;
        wait_rv(1'b1, 20, seen);
        tests_run++;
        if (got != 10 || both) begin
            tests_failed++;
            $display("FAIL starve_count got grants=%0d both=%b required 10 0", got, both);
        end
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (seq[i] !== ((i % 5) == 4)) begin
                tests_failed++;
                $display("FAIL starve_seq[%0d] got is_if=%b required is_if=%b",
                         i, seq[i], ((i % 5) == 4));
            end
        end
    endtask

    task automatic test_write();
        bit seen;
        mm_lat = 3; mm_next_data = 32'hFFFF_FFFF;
        drv_d_req = 1'b1; drv_d_we = 1'b1; drv_d_addr = 32'h40;
        drv_d_wdata = 32'h12345678; drv_d_be = 4'h3;
        cycle();
        tests_run++;
        if (d_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_gnt got=%b required=1", d_gnt);
        end
        drv_d_req = 1'b0; drv_d_we = 1'b0;
        cycle();
        tests_run++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 ||
            mem_wdata !== 32'h12345678 || mem_be !== 4'h3) begin
            tests_failed++;
            $display("FAIL write_issue got req=%b we=%b addr=%h wdata=%h be=%h required 1 1 00000040 12345678 3",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be);
        end
        wait_rv(1'b0, 20, seen);
        tests_run++;
        if (!seen || d_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL write_ack got seen=%b data=%h required 1 00000000", seen, d_rdata);
        end
    endtask

    task automatic test_reset_mid();
        bit bad, seen;
        mm_lat = 5; mm_next_data = 32'h1111_2222;
        drv_if_req = 1'b1; drv_if_addr = 32'h300;
        cycle();
        drv_if_req = 1'b0;
        cycle();
        cycle();
        drv_rst = 1'b1;
        cycle();
        drv_rst = 1'b0;
        cycle();
        tests_run++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we} !== 6'b0 ||
            {mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs got ctrl=%b addr=%h be=%h if_rdata=%h required all 0",
                     {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we}, mem_addr, mem_be, if_rdata);
        end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (if_rvalid || d_rvalid || mem_req) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL rst_mid_late_rv got spurious activity=%b required=0", bad);
        end
        mm_lat = 2; mm_next_data = 32'hCAFEF00D;
        drv_if_req = 1'b1; drv_if_addr = 32'h500;
        cycle();
        tests_run++;
        if (if_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_regrant got if_gnt=%b required=1", if_gnt);
        end
        drv_if_req = 1'b0;
        cycle();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            tests_failed++;
            $display("FAIL rst_mid_issue got req=%b addr=%h required 1 00000500", mem_req, mem_addr);
        end
        wait_rv(1'b1, 20, seen);
        tests_run++;
        if (!seen || if_rdata !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL rst_mid_resp got seen=%b data=%h required 1 cafef00d", seen, if_rdata);
        end
    endtask

`ifdef RISCV_MEM_ARB_PERF_EN
    task automatic test_perf();
        logic [31:0] base_if, base_d;
        bit got, seen;
        mm_lat = 3; mm_next_data = 32'h5;
        drv_d_req = 1'b1; drv_d_we = 1'b0; drv_d_addr = 32'h20;
        cycle();
        base_if = perf_if_stall; base_d = perf_d_stall;
        drv_d_req = 1'b0; drv_if_req = 1'b1; drv_if_addr = 32'h24;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (if_gnt) begin got = 1'b1; break; end
        end
        tests_run++;
        if (!got || (perf_if_stall - base_if) !== 32'd5 || (perf_d_stall - base_d) !== 32'd0) begin
            tests_failed++;
            $display("FAIL perf_stall got gnt=%b if_delta=%0d d_delta=%0d required 1 5 0",
                     got, perf_if_stall - base_if, perf_d_stall - base_d);
        end
        drv_if_req = 1'b0;
        wait_rv(1'b1, 20, seen);
    endtask
`endif

    task automatic test_random();
        bit ifp = 0, dp = 0, dwe = 0;
        logic [31:0] ia = '0, da = '0, dwd = '0;
        logic [3:0] dbe = '0;
        int streak = 0, g_cyc = 0, r_cyc = -1;
        bit busy = 0, was_idle, tx_if = 0, tx_we = 0;
        logic [31:0] tx_addr = '0, tx_wdata = '0, tx_rdata = '0;
        logic [3:0] tx_be = '0;
        bit e_if, e_d, e_req, e_ifrv, e_drv;
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            if (!ifp && $urandom_range(0, 2) != 0) begin
                ifp = 1; ia = $urandom;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; dwe = 1'($urandom_range(0, 1)); da = $urandom; dwd = $urandom;
                dbe = 4'($urandom_range(0, 15));
            end
            drv_if_req = ifp; drv_if_addr = ia;
            drv_d_req = dp; drv_d_we = dwe; drv_d_addr = da; drv_d_wdata = dwd; drv_d_be = dbe;
            mm_lat = $urandom_range(1, 4); mm_next_data = $urandom;
            cycle();

            was_idle = !busy;
            e_if = 0; e_d = 0;
            if (was_idle && (ifp || dp)) begin
                if (ifp && (!dp || streak >= LIMIT)) e_if = 1; else e_d = 1;
            end
            e_req  = busy && (cyc == g_cyc + 1);
            e_ifrv = busy && r_cyc >= 0 && cyc == r_cyc + 1 && tx_if;
            e_drv  = busy && r_cyc >= 0 && cyc == r_cyc + 1 && !tx_if;

            tests_run++;
            if ({if_gnt, d_gnt} !== {e_if, e_d}) begin
                tests_failed++;
                $display("FAIL rnd_gnt cyc=%0d got if=%b d=%b required if=%b d=%b",
                         cyc, if_gnt, d_gnt, e_if, e_d);
            end
            tests_run++;
            if (mem_req !== e_req) begin
                tests_failed++;
                $display("FAIL rnd_mem_req cyc=%0d got=%b required=%b", cyc, mem_req, e_req);
            end
            if (e_req) begin
                tests_run++;
                if (mem_we !== tx_we || mem_addr !== tx_addr || mem_be !== tx_be ||
                    (!tx_if && mem_wdata !== tx_wdata)) begin
                    tests_failed++;
                    $display("FAIL rnd_mem_fields cyc=%0d got we=%b a=%h wd=%h be=%h required we=%b a=%h wd=%h be=%h",
                             cyc, mem_we, mem_addr, mem_wdata, mem_be, tx_we, tx_addr, tx_wdata, tx_be);
                end
            end
            tests_run++;
            if ({if_rvalid, d_rvalid} !== {e_ifrv, e_drv}) begin
                tests_failed++;
                $display("FAIL rnd_rvalid cyc=%0d got if=%b d=%b required if=%b d=%b",
                         cyc, if_rvalid, d_rvalid, e_ifrv, e_drv);
            end
            if (e_ifrv || e_drv) begin
                tests_run++;
                if ((e_ifrv ? if_rdata : d_rdata) !== tx_rdata) begin
                    tests_failed++;
                    $display("FAIL rnd_rdata cyc=%0d got=%h required=%h",
                             cyc, e_ifrv ? if_rdata : d_rdata, tx_rdata);
                end
            end

            if (busy && r_cyc >= 0 && cyc == r_cyc + 1) busy = 0;
            if (busy && r_cyc < 0 && cyc > g_cyc + 1 && mem_rvalid) begin
                r_cyc = cyc; tx_rdata = tx_we ? 32'h0 : mem_rdata;
            end
            if (e_if) begin
                busy = 1; g_cyc = cyc; r_cyc = -1; tx_if = 1; tx_we = 0;
                tx_addr = ia; tx_wdata = '0; tx_be = 4'hF; ifp = 0; streak = 0;
            end else if (e_d) begin
                busy = 1; g_cyc = cyc; r_cyc = -1; tx_if = 0; tx_we = dwe;
                tx_addr = da; tx_wdata = dwd; tx_be = dbe; dp = 0;
                streak = ifp ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
            end else if (was_idle) begin
                streak = 0;
            end
        end
        drv_if_req = 1'b0; drv_d_req = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin
            cycle();
            if (busy && r_cyc < 0 && cyc > g_cyc + 1 && mem_rvalid) r_cyc = cyc;
            if (busy && r_cyc >= 0 && cyc == r_cyc + 1) busy = 0;
        end
        tests_run++;
        if (busy) begin
            tests_failed++;
            $display("FAIL rnd_drain got busy=%b required=0", busy);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_write();
        test_reset_mid();
`ifdef RISCV_MEM_ARB_PERF_EN
        test_perf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch requester and data requester.
- Converts the Harvard split interface into a single memory port.
- Sequences one transaction at a time through a small FSM.
- Data has priority; a starvation limit guarantees fetch forward progress.
- Sits between the core front-end/LSU handshake wrappers and the memory model or SRAM macro.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports.
- STARVE_LIMIT, 4, max consecutive data grants while if_req is pending; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req && !if_gnt
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle fetch response strobe
- if_rdata  out  DATA_W  fetch data; valid with if_rvalid
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  4  byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle data response (read data or write ack)
- d_rdata  out  DATA_W  read data; 0 for write ack
- mem_req  out  1  memory request, one-cycle pulse
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables; 4'hF for fetches
- mem_rvalid  in  1  memory completion; latency >= 1 cycle after mem_req
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. At most one transaction outstanding.
- IDLE:
  - If any request is present: assert the selected requester's gnt combinationally in the same cycle.
  - Latch addr, we, wdata, be and owner into registers; go to ISSUE.
  - No request: stay in IDLE.
- Selection:
  - d_req wins, unless if_req=1 and starve_cnt == STARVE_LIMIT; then fetch wins.
  - Only one gnt is ever high in a cycle.
- starve_cnt:
  - Increments on a data grant while if_req=1; saturates at STARVE_LIMIT.
  - Clears on a fetch grant, or at any arbitration with if_req=0.
- ISSUE:
  - mem_req=1 for exactly one cycle, driven from the latched registers; go to WAIT.
  - For fetches: mem_we=0, mem_be=4'hF.
- WAIT:
  - Latched mem_* outputs hold; mem_req=0.
  - On mem_rvalid: capture mem_rdata (forced to 0 for writes); go to RESP.
- RESP:
  - Assert the owner's rvalid for one cycle with the registered rdata; go to IDLE.
  - No new grant is issued in RESP.
- mem_rvalid is ignored outside WAIT; it causes no response and no state change.
- Latency: gnt at cycle 0, mem_req at cycle 1, mem_rvalid at cycle 1+L, owner rvalid at cycle 2+L. Back-to-back throughput is one transaction per 3+L cycles.
- Reset (any state, including mid-transaction):
  - State to IDLE, starve_cnt to 0.
  - All outputs 0: gnt, rvalid, mem_req, mem_we, mem_addr, mem_wdata, mem_be, rdata.
  - Any in-flight memory response is discarded.
- Simultaneous if_req and d_req in IDLE are resolved by the selection rule. The loser sees gnt=0 and must keep its request asserted.
- Requests arriving while not in IDLE get gnt=0.

Optional Feature:
- Macro: RISCV_MEM_ARB_PERF_EN.
- Defined: adds outputs perf_if_stall [31:0] and perf_d_stall [31:0].
  - Each counts cycles where that requester's req=1 && gnt=0.
  - Wrap-around at 2^32, cleared by rst.
- Undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- Package riscv_mem_arb_pkg:
  - arb_state_e enum {IDLE, ISSUE, WAIT, RESP}.
  - arb_owner_e enum {OWN_IF, OWN_D}.
  - Constants ADDR_W_DEF=32, DATA_W_DEF=32, BE_W=4.
- Sub-module riscv_mem_arb_fairness:
  - Holds starve_cnt.
  - Inputs: if_req, d_grant, if_grant, arb_cycle.
  - Output: force_if.

Test Plan:
- Single fetch, L=2: if_req, if_addr=0x100, mem_rdata=0xDEADBEEF -> if_gnt cycle 0, mem_req cycle 1 with mem_addr=0x100 and mem_be=F, if_rvalid cycle 4 with if_rdata=0xDEADBEEF.
- Simultaneous if_req and d_req (read 0x200), starve_cnt=0 -> d_gnt first, d_rvalid delivered, then if_gnt at the next IDLE cycle.
- Starvation: d_req and if_req held high continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
- Write: d_we=1, d_addr=0x40, d_wdata=0x12345678, d_be=0x3 -> mem_we=1 with matching addr, wdata and be; d_rvalid with d_rdata=0.
- Reset in WAIT, then a late mem_rvalid -> all outputs 0, no rvalid, FSM stays IDLE; a subsequent fetch completes normally.
- With RISCV_MEM_ARB_PERF_EN: if_req blocked 5 cycles behind a data transaction -> perf_if_stall=5.
